bcd_display_scan: RTL and testbench

Time-multiplexed driver for a 4-digit common-anode seven-segment display, consuming the 16-bit packed BCD word produced by the binary-to-BCD converter (`convert_to_bcd`). It latches a new value on a load strobe and applies it only at a frame boundary, so a scan never shows a mix of old and new digits. It scans one digit at a time at a programmable rate, with optional leading-zero blanking and an anti-ghosting blank slot. All outputs are registered.

---
 rtl/bcd_display_scan.sv | 123 ++++++++++++
 tb/tb_bcd_display_scan.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/bcd_display_scan.sv
// Time-multiplexed 4-digit common-anode seven-segment driver for packed BCD.
// New values are double-buffered and only applied at a frame boundary, so a scan never tears.
module bcd_display_scan #(
  parameter int unsigned DIV = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [15:0] bcd_in,
  input  logic        blank_lz,
  output logic [6:0]  seg_n,
  output logic [3:0]  an_n,
  output logic        frame
);

  localparam logic [15:0] CntMax = 16'(DIV - 1);

  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] shadow_q, shadow_d;
  logic        pending_q, pending_d;
  logic [15:0] disp_q, disp_d;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;
  logic        frame_q, frame_d;

  logic        wrap;
  logic [3:0]  nibble;
  logic [3:0]  nzNib;
  logic        blanked;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  always_comb begin
    wrap      = (idx_q == 2'd3) && (cnt_q == CntMax);
    cnt_d     = cnt_q + 16'd1;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    disp_d    = disp_q;
    frame_d   = wrap;

    if (cnt_q == CntMax) begin
      cnt_d = 16'd0;
      idx_d = idx_q + 2'd1;
    end

    // A load landing exactly on the wrap bypasses the shadow so it shows in the very next frame
    if (load && wrap) begin
      shadow_d  = bcd_in;
      disp_d    = bcd_in;
      pending_d = 1'b0;
    end else if (load) begin
      shadow_d  = bcd_in;
      pending_d = 1'b1;
    end else if (wrap && pending_q) begin
      disp_d    = shadow_q;
      pending_d = 1'b0;
    end

    nibble = disp_q[{idx_q, 2'b00} +: 4];
    for (int i = 0; i < 4; i++) begin
      nzNib[i] = |disp_q[4*i +: 4];
    end

    case (idx_q)
      2'd1:    blanked = blank_lz && !(|nzNib[3:1]);
      2'd2:    blanked = blank_lz && !(|nzNib[3:2]);
      2'd3:    blanked = blank_lz && !nzNib[3];
      default: blanked = 1'b0;
    endcase

    // First cycle of every slot stays dark so the previous digit's segments cannot ghost
    if ((cnt_q == 16'd0) || blanked) begin
      an_d  = 4'hF;
      seg_d = 7'h7F;
    end else begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = decode(nibble);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q     <= 16'd0;
      idx_q     <= 2'd0;
      shadow_q  <= 16'd0;
      pending_q <= 1'b0;
      disp_q    <= 16'd0;
      seg_q     <= 7'h7F;
      an_q      <= 4'hF;
      frame_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      disp_q    <= disp_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      frame_q   <= frame_d;
    end
  end

  assign seg_n = seg_q;
  assign an_n  = an_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Self-checking bench for bcd_display_scan: directed scenarios plus random traffic,
// every cycle compared against a cycle-count based reference model.
module tb_bcd_display_scan;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] bcdIn = 16'h0000;
  logic        blankLz = 1'b0;
  logic [6:0]  segN;
  logic [3:0]  anN;
  logic        frame;

  int checks = 0;
  int failures = 0;

  // Reference model: position in the scan is derived purely from cycles since reset
  int          mTick;
  logic [15:0] mDisp, mShadow;
  logic        mPending;
  logic [6:0]  expSeg;
  logic [3:0]  expAn;
  logic        expFrame;
  logic [6:0]  patterns [16];

  bcd_display_scan #(.DIV(DIV)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .bcd_in  (bcdIn),
    .blank_lz(blankLz),
    .seg_n   (segN),
    .an_n    (anN),
    .frame   (frame)
  );

  always #5 clk = ~clk;

  function automatic int curCnt();
    return mTick % DIV;
  endfunction

  function automatic int curIdx();
    return (mTick / DIV) % 4;
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %h expected %h (tick %0d)", tag, observed, expected, mTick);
    end
  endtask

  task automatic modelEdge();
    int  c, d, digit;
    bit  wrap, dark;
    if (!reset_n) begin
      mTick = 0; mDisp = 0; mShadow = 0; mPending = 0;
      expSeg = 7'h7F; expAn = 4'hF; expFrame = 0;
    end else begin
      c = curCnt();
      d = curIdx();
      wrap = (d == 3) && (c == DIV - 1);
      digit = (mDisp >> (4 * d)) & 15;
      dark = (c == 0) || (d >= 1 && blankLz && ((mDisp >> (4 * d)) == 0));
      expAn = dark ? 4'hF : 4'(15 - (1 << d));
      expSeg = dark ? 7'h7F : patterns[digit];
      expFrame = wrap;
      if (load && wrap) begin
        mDisp = bcdIn; mShadow = bcdIn; mPending = 0;
      end else if (load) begin
        mShadow = bcdIn; mPending = 1;
      end else if (wrap && mPending) begin
        mDisp = mShadow; mPending = 0;
      end
      mTick++;
    end
  endtask

  task automatic applyStimulus(input logic rstN, input logic ld, input logic [15:0] val, input logic blz);
    reset_n = rstN; load = ld; bcdIn = val; blankLz = blz;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput("an_n", 16'(anN), 16'(expAn));
    checkOutput("seg_n", 16'(segN), 16'(expSeg));
    checkOutput("frame", 16'(frame), 16'(expFrame));
    load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, bcdIn, blankLz);
  endtask

  // Bounded advance until the model's next edge lands on the given slot position
  task automatic advanceTo(input int idx, input int cnt);
    for (int i = 0; i < 8 * DIV; i++) begin
      if (curIdx() == idx && curCnt() == cnt) return;
      idle(1);
    end
    checkOutput("advance_timeout", 16'd1, 16'd0);
  endtask

  initial begin
    patterns[0] = 7'b1000000; patterns[1] = 7'b1111001; patterns[2] = 7'b0100100;
    patterns[3] = 7'b0110000; patterns[4] = 7'b0011001; patterns[5] = 7'b0010010;
    patterns[6] = 7'b0000010; patterns[7] = 7'b1111000; patterns[8] = 7'b0000000;
    patterns[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) patterns[i] = 7'b0111111;

    // Reset and first digit
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    checkOutput("first_dark_an", 16'(anN), 16'hF);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    checkOutput("first_lit_an", 16'(anN), 16'b1110);
    checkOutput("first_lit_seg", 16'(segN), 16'b1000000);

    // Full scan of 1234 loaded just after a frame pulse
    advanceTo(0, 0);
    applyStimulus(1'b1, 1'b1, 16'h1234, 1'b0);
    idle(8 * DIV);

    // Tear-free update mid-frame, then a load right on the wrap cycle
    advanceTo(1, 1);
    applyStimulus(1'b1, 1'b1, 16'h9999, 1'b0);
    idle(6 * DIV);
    advanceTo(3, DIV - 1);
    applyStimulus(1'b1, 1'b1, 16'h5678, 1'b0);
    idle(4 * DIV);

    // Leading-zero blanking
    applyStimulus(1'b1, 1'b1, 16'h0050, 1'b1);
    idle(8 * DIV);
    applyStimulus(1'b1, 1'b1, 16'h0000, 1'b1);
    idle(8 * DIV);

    // Invalid nibbles
    applyStimulus(1'b1, 1'b1, 16'h1A0F, 1'b0);
    idle(8 * DIV);

    // Reset before the pending 7777 can reach the display
    advanceTo(0, 2);
    applyStimulus(1'b1, 1'b1, 16'h7777, 1'b0);
    idle(DIV);
    applyStimulus(1'b0, 1'b0, 16'h7777, 1'b0);
    idle(8 * DIV);

    // Random traffic with occasional resets and blanking changes
    for (int i = 0; i < 1500; i++) begin
      logic rn, ld, blz;
      logic [15:0] v;
      rn = ($urandom_range(0, 199) != 0);
      ld = ($urandom_range(0, 9) == 0);
      blz = ($urandom_range(0, 19) == 0) ? ~blankLz : blankLz;
      if ($urandom_range(0, 3) == 0) v = 16'($urandom);
      else v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      if ($urandom_range(0, 2) == 0) v = v & 16'h00FF;
      applyStimulus(rn, ld, v, blz);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
